// File: rtl/chroma_interp_pipe.sv
// Bilinear chroma interpolator: LANES samples per beat, 3-stage valid/ready pipeline.
// Optional 2-entry input skid buffer (adds one cycle of latency) enabled by MC_CHROMA_SKID_EN.
module chroma_interp_pipe #(
  parameter int BIT_DEPTH = 8,
  parameter int FRAC_BITS = 3,
  parameter int LANES     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FRAC_BITS-1:0]         xfrac,
  input  logic [FRAC_BITS-1:0]         yfrac,
  input  logic [LANES*BIT_DEPTH-1:0]   a_pix,
  input  logic [LANES*BIT_DEPTH-1:0]   b_pix,
  input  logic [LANES*BIT_DEPTH-1:0]   c_pix,
  input  logic [LANES*BIT_DEPTH-1:0]   d_pix,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*BIT_DEPTH-1:0]   out_pix,
  output logic                         out_last
);

  localparam int PW    = LANES * BIT_DEPTH;
  localparam int WW    = FRAC_BITS + 1;
  localparam int SUM_W = BIT_DEPTH + 2 * FRAC_BITS;
  localparam int S     = 1 << FRAC_BITS;
  localparam int RND   = 1 << (2 * FRAC_BITS - 1);

  logic                 s1_adv, s2_adv, s3_adv;
  logic                 src_valid;
  logic [FRAC_BITS-1:0] src_x, src_y;
  logic [PW-1:0]        src_a, src_b, src_c, src_d;
  logic                 src_last;

`ifdef MC_CHROMA_SKID_EN
  localparam int EW = 2 * FRAC_BITS + 4 * PW + 1;

  logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [EW-1:0] in_ent, head;
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          in_ready_q, in_ready_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;

  assign in_ent    = {xfrac, yfrac, a_pix, b_pix, c_pix, d_pix, in_last};
  assign push      = in_valid & in_ready_q;
  assign pop       = src_valid & s1_adv;
  assign head      = rd_ptr_q ? ent1_q : ent0_q;
  assign src_valid = (cnt_q != 2'd0);
  assign {src_x, src_y, src_a, src_b, src_c, src_d, src_last} = head;
  assign in_ready  = in_ready_q;

  // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      if (wr_ptr_q) ent1_d = in_ent;
      else          ent0_d = in_ent;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign src_valid = in_valid;
  assign src_x     = xfrac;
  assign src_y     = yfrac;
  assign src_a     = a_pix;
  assign src_b     = b_pix;
  assign src_c     = c_pix;
  assign src_d     = d_pix;
  assign src_last  = in_last;
  assign in_ready  = rst_n & s1_adv;
`endif

  // Stage registers
  logic          s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [WW-1:0] wx0_q, wx0_d, wx1_q, wx1_d, wy0_q, wy0_d, wy1_q, wy1_d;
  logic [PW-1:0] a1_q, a1_d, b1_q, b1_d, c1_q, c1_d, d1_q, d1_d;
  logic          last1_q, last1_d, last2_q, last2_d;
  logic [PW-1:0] out_pix_q, out_pix_d;
  logic          out_last_q, out_last_d;
  wire  [PW-1:0] pix_res;

  assign s3_adv = !s3_v_q | out_ready;
  assign s2_adv = !s2_v_q | s3_adv;
  assign s1_adv = !s1_v_q | s2_adv;

  always_comb begin
    s1_v_d     = s1_adv ? src_valid : s1_v_q;
    wx0_d      = s1_adv ? (WW'(S) - WW'(src_x)) : wx0_q;
    wx1_d      = s1_adv ? WW'(src_x) : wx1_q;
    wy0_d      = s1_adv ? (WW'(S) - WW'(src_y)) : wy0_q;
    wy1_d      = s1_adv ? WW'(src_y) : wy1_q;
    a1_d       = s1_adv ? src_a : a1_q;
    b1_d       = s1_adv ? src_b : b1_q;
    c1_d       = s1_adv ? src_c : c1_q;
    d1_d       = s1_adv ? src_d : d1_q;
    last1_d    = s1_adv ? src_last : last1_q;
    s2_v_d     = s2_adv ? s1_v_q : s2_v_q;
    last2_d    = s2_adv ? last1_q : last2_q;
    s3_v_d     = s3_adv ? s2_v_q : s3_v_q;
    out_pix_d  = s3_adv ? pix_res : out_pix_q;
    out_last_d = s3_adv ? last2_q : out_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      wx0_q      <= '0;
      wx1_q      <= '0;
      wy0_q      <= '0;
      wy1_q      <= '0;
      a1_q       <= '0;
      b1_q       <= '0;
      c1_q       <= '0;
      d1_q       <= '0;
      last1_q    <= 1'b0;
      last2_q    <= 1'b0;
      out_pix_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s3_v_q     <= s3_v_d;
      wx0_q      <= wx0_d;
      wx1_q      <= wx1_d;
      wy0_q      <= wy0_d;
      wy1_q      <= wy1_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      c1_q       <= c1_d;
      d1_q       <= d1_d;
      last1_q    <= last1_d;
      last2_q    <= last2_d;
      out_pix_q  <= out_pix_d;
      out_last_q <= out_last_d;
    end
  end

  // Products fit SUM_W bits because each is at most S*S*(2^BIT_DEPTH-1)
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BIT_DEPTH-1:0] a_l, b_l, c_l, d_l;
      logic [SUM_W-1:0]     p_q [4];
      logic [SUM_W-1:0]     p_d [4];
      logic [SUM_W-1:0]     sum;

      assign a_l = a1_q[gi*BIT_DEPTH +: BIT_DEPTH];
      assign b_l = b1_q[gi*BIT_DEPTH +: BIT_DEPTH];
      assign c_l = c1_q[gi*BIT_DEPTH +: BIT_DEPTH];
      assign d_l = d1_q[gi*BIT_DEPTH +: BIT_DEPTH];

      always_comb begin
        p_d = p_q;
        if (s2_adv) begin
          p_d[0] = SUM_W'(wx0_q) * SUM_W'(wy0_q) * SUM_W'(a_l);
          p_d[1] = SUM_W'(wx1_q) * SUM_W'(wy0_q) * SUM_W'(b_l);
          p_d[2] = SUM_W'(wx0_q) * SUM_W'(wy1_q) * SUM_W'(c_l);
          p_d[3] = SUM_W'(wx1_q) * SUM_W'(wy1_q) * SUM_W'(d_l);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= '{default: '0};
        else        p_q <= p_d;
      end

      assign sum = p_q[0] + p_q[1] + p_q[2] + p_q[3];
      assign pix_res[gi*BIT_DEPTH +: BIT_DEPTH] =
        BIT_DEPTH'((sum + SUM_W'(RND)) >> (2 * FRAC_BITS));
    end
  endgenerate

  assign out_valid = s3_v_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;

endmodule
